logic_unit_seq: RTL and testbench

Parametrised, registered successor to the team's two-input gate modules (NAND/NOR/XOR). It applies one of eight bitwise operations to WIDTH-bit operands under a valid/ready handshake. It runs in one of two modes: direct, giving one result per beat, or fold, which XOR-accumulates the per-beat results over a programmed number of beats. It sits between an operand source and a result sink in lab datapaths and replaces the purely combinational gate blocks where a registered, flow-controlled result is needed.

---
 rtl/logic_unit_seq.sv | 187 ++++++++++++++++++
 tb/tb_logic_unit_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_seq.sv
// logic_unit_seq: registered eight-way bitwise unit with valid/ready handshake.
// Direct mode returns op(a,b) per beat; fold mode XOR-accumulates B beats.
module logic_unit_seq #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAXBEATS = 16,
    localparam int unsigned CW      = $clog2(MAXBEATS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       op,
    input  logic             fold,
    input  logic [CW-1:0]    beats,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             parity,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CW-1:0]    cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [CW-1:0]    blen_q, blen_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             zero_q, zero_d;
    logic             parity_q, parity_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [2:0]       op_eff;
    logic [WIDTH-1:0] r;
    logic             space;
    logic [CW-1:0]    beats_eff;
    logic             last_beat;
    logic             load;
    logic [WIDTH-1:0] load_val;

    // Per-beat bitwise operation.
    function automatic logic [WIDTH-1:0] apply_op(input logic [2:0] o,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] z);
        logic [WIDTH-1:0] res;
        case (o)
            3'd0:    res = ~(x & z);
            3'd1:    res = ~(x | z);
            3'd2:    res = x ^ z;
            3'd3:    res = x & z;
            3'd4:    res = x | z;
            3'd5:    res = ~(x ^ z);
            3'd6:    res = x;
            default: res = ~x;
        endcase
        return res;
    endfunction

    // Next-state, handshake and output-register load logic.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        blen_d      = blen_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        y_d         = y_q;
        out_valid_d = out_valid_q;
        load        = 1'b0;
        load_val    = '0;

        // During a fold the latched op is used; live op is ignored.
        op_eff    = (state_q == ACC) ? op_q : op;
        r         = apply_op(op_eff, a, b);
        space     = !out_valid_q || out_ready;
        last_beat = (cnt_q == (blen_q - CW'(1)));

        if (beats == '0) begin
            beats_eff = CW'(1);
        end else if (beats > CW'(MAXBEATS)) begin
            beats_eff = CW'(MAXBEATS);
        end else begin
            beats_eff = beats;
        end

        in_ready = space;

        case (state_q)
            IDLE: begin
                in_ready = space;
                if (in_valid && space) begin
                    if (fold && (beats_eff != CW'(1))) begin
                        state_d = ACC;
                        op_d    = op;
                        blen_d  = beats_eff;
                        acc_d   = r;
                        cnt_d   = CW'(1);
                    end else begin
                        // Direct beat, or a single-beat fold that completes at once.
                        if (fold) begin
                            acc_d = r;
                        end
                        cnt_d    = '0;
                        load     = 1'b1;
                        load_val = r;
                    end
                end
            end
            ACC: begin
                if (last_beat) begin
                    in_ready = space;
                    if (in_valid && space) begin
                        load     = 1'b1;
                        load_val = acc_q ^ r;
                        cnt_d    = '0;
                        state_d  = IDLE;
                    end
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        acc_d = acc_q ^ r;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Output entry: a new load wins over a drain in the same cycle.
        if (load) begin
            y_d         = load_val;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            y_d         = '0;
            out_valid_d = 1'b0;
        end

        zero_d   = (y_d == '0);
        parity_d = ^y_d;
        busy_d   = (state_d == ACC);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= 3'd0;
            blen_q      <= CW'(1);
            acc_q       <= '0;
            cnt_q       <= '0;
            y_q         <= '0;
            zero_q      <= 1'b1;
            parity_q    <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            blen_q      <= blen_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            y_q         <= y_d;
            zero_q      <= zero_d;
            parity_q    <= parity_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign y         = y_q;
    assign zero      = zero_q;
    assign parity    = parity_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign cnt       = cnt_q;

endmodule

// File: tb/tb_logic_unit_seq.sv
// Directed bench for logic_unit_seq with hand-computed expectations.
module tb_logic_unit_seq;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned MAXBEATS = 16;
    localparam int unsigned CW       = $clog2(MAXBEATS + 1);

    logic             clk;
    logic             rst;
    logic [2:0]       op;
    logic             fold;
    logic [CW-1:0]    beats;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             parity;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic [CW-1:0]    cnt;

    int checks;
    int failures;

    logic [7:0] exp_dir [8];

    logic_unit_seq #(.WIDTH(WIDTH), .MAXBEATS(MAXBEATS)) dut (
        .clk       (clk),
        .rst       (rst),
        .op        (op),
        .fold      (fold),
        .beats     (beats),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .zero      (zero),
        .parity    (parity),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .cnt       (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        exp_dir[0] = 8'hCF; exp_dir[1] = 8'h03; exp_dir[2] = 8'hCC; exp_dir[3] = 8'h30;
        exp_dir[4] = 8'hFC; exp_dir[5] = 8'h33; exp_dir[6] = 8'hF0; exp_dir[7] = 8'h0F;

        rst = 1'b1; op = 3'd0; fold = 1'b0; beats = '0; a = '0; b = '0;
        in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y",         32'(y),         32'h00);
        check("rst_zero",      32'(zero),      32'd1);
        check("rst_parity",    32'(parity),    32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_cnt",       32'(cnt),       32'd0);

        // Reset in the middle of a 4-beat fold
        fold = 1'b1; beats = CW'(4); op = 3'd2; a = 8'h01; b = 8'h00; in_valid = 1'b1;
        tick();
        check("midrst_busy1", 32'(busy), 32'd1);
        check("midrst_cnt1",  32'(cnt),  32'd1);
        tick();
        check("midrst_cnt2",  32'(cnt),  32'd2);
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_y",         32'(y),         32'h00);
        check("midrst_zero",      32'(zero),      32'd1);
        check("midrst_busy",      32'(busy),      32'd0);
        check("midrst_cnt",       32'(cnt),       32'd0);

        // Direct beat after reset
        fold = 1'b0; op = 3'd3; a = 8'hFF; b = 8'h81; in_valid = 1'b1;
        tick();
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_y",     32'(y),         32'h81);

        // All eight direct operations on a=F0, b=3C
        a = 8'hF0; b = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            op = 3'(i);
            tick();
            check($sformatf("dir_op%0d_y", i),     32'(y),         32'(exp_dir[i]));
            check($sformatf("dir_op%0d_valid", i), 32'(out_valid), 32'd1);
            if (i == 0) begin
                check("dir_op0_parity", 32'(parity), 32'd0);
                check("dir_op0_zero",   32'(zero),   32'd0);
            end
        end
        in_valid = 1'b0;
        tick();
        check("dir_drain_valid", 32'(out_valid), 32'd0);

        // XOR fold of three beats; op/fold inputs changed mid-fold
        fold = 1'b1; beats = CW'(3); op = 3'd2; a = 8'h01; b = 8'h00; in_valid = 1'b1;
        #1;
        check("fold_first_ready", 32'(in_ready), 32'd1);
        tick();
        check("fold_b1_busy",  32'(busy),      32'd1);
        check("fold_b1_cnt",   32'(cnt),       32'd1);
        check("fold_b1_valid", 32'(out_valid), 32'd0);
        op = 3'd3; fold = 1'b0; a = 8'h02;
        tick();
        check("fold_b2_cnt",   32'(cnt),       32'd2);
        check("fold_b2_valid", 32'(out_valid), 32'd0);
        a = 8'h04;
        tick();
        check("fold_b3_valid",  32'(out_valid), 32'd1);
        check("fold_b3_y",      32'(y),         32'h07);
        check("fold_b3_parity", 32'(parity),    32'd1);
        check("fold_b3_busy",   32'(busy),      32'd0);
        check("fold_b3_cnt",    32'(cnt),       32'd0);
        in_valid = 1'b0;
        tick();

        // Backpressure on a held direct result
        fold = 1'b0; op = 3'd6; a = 8'h5A; b = 8'h00; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        check("bp_first_y", 32'(y), 32'h5A);
        out_ready = 1'b0; a = 8'h11;
        #1;
        check("bp_ready_low", 32'(in_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp_hold_y%0d", i), 32'(y), 32'h5A);
        end
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        #1;
        check("bp_ready_high", 32'(in_ready), 32'd1);
        tick();
        check("bp_swap_valid", 32'(out_valid), 32'd1);
        check("bp_swap_y",     32'(y),         32'h11);
        in_valid = 1'b0;
        tick();
        check("bp_drain_valid", 32'(out_valid), 32'd0);

        // beats=0 acts as a single-beat fold
        fold = 1'b1; beats = '0; op = 3'd2; a = 8'h3C; b = 8'h0F; in_valid = 1'b1;
        tick();
        check("b0_valid", 32'(out_valid), 32'd1);
        check("b0_y",     32'(y),         32'h33);
        check("b0_busy",  32'(busy),      32'd0);
        in_valid = 1'b0;
        tick();

        // Longest fold: MAXBEATS beats of pass(0xFF)
        fold = 1'b1; beats = CW'(MAXBEATS); op = 3'd6; a = 8'hFF; b = 8'h00; in_valid = 1'b1;
        for (int i = 1; i < int'(MAXBEATS); i++) begin
            tick();
            check($sformatf("max_cnt%0d", i), 32'(cnt), 32'(i));
            check($sformatf("max_busy%0d", i), 32'({busy, out_valid}), 32'b10);
        end
        tick();
        check("max_cnt_end", 32'(cnt),       32'd0);
        check("max_valid",   32'(out_valid), 32'd1);
        check("max_y",       32'(y),         (MAXBEATS % 2 == 0) ? 32'h00 : 32'hFF);
        check("max_busy",    32'(busy),      32'd0);
        in_valid = 1'b0;
        tick();

        // Stalls: non-final beats ignore out_ready; IDLE beats wait on a held result
        fold = 1'b1; beats = CW'(3); op = 3'd2; a = 8'h01; b = 8'h02; in_valid = 1'b1; out_ready = 1'b0;
        #1;
        check("st_first_ready", 32'(in_ready), 32'd1);
        tick();
        check("st_cnt1", 32'(cnt), 32'd1);
        a = 8'h04; b = 8'h00;
        #1;
        check("st_nonfinal_ready", 32'(in_ready), 32'd1);
        tick();
        check("st_cnt2", 32'(cnt), 32'd2);
        a = 8'h08;
        tick();
        check("st_final_valid", 32'(out_valid), 32'd1);
        check("st_final_y",     32'(y),         32'h0F);
        beats = CW'(2); a = 8'hFF; b = 8'h00;
        #1;
        check("st_full_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("st_wait_y%0d", i), 32'(y), 32'h0F);
            check($sformatf("st_wait_cnt%0d", i), 32'({busy, cnt}), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("st_release_ready", 32'(in_ready), 32'd1);
        tick();
        check("st_release_cnt",   32'(cnt),       32'd1);
        check("st_release_valid", 32'(out_valid), 32'd0);
        a = 8'h0F; out_ready = 1'b0;
        tick();
        check("st_last_valid", 32'(out_valid), 32'd1);
        check("st_last_y",     32'(y),         32'hF0);
        in_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
